// File: rtl/demux_seq_if.sv
// Demux bundle: one upstream beat channel fanned out to CHANNELS one-entry outputs.
// Carries the upstream handshake, select/mode controls and all per-channel outputs.
// The slave side is the demux; the master side is whoever feeds and drains it.
interface demux_seq_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [SEL_W-1:0]          ptr;
  logic                      sel_err;

  modport master (
    output in_valid, in_data, sel, mode, out_ready,
    input  in_ready, out_valid, out_data, ptr, sel_err
  );

  modport slave (
    input  in_valid, in_data, sel, mode, out_ready,
    output in_ready, out_valid, out_data, ptr, sel_err
  );
endinterface

// File: rtl/demux_seq.sv
// Sequential demux: routes each accepted beat to a manually selected or round-robin channel.
// Latency 1 cycle from accept to out_valid; each channel holds one beat.
// in_ready drops only when the target channel is full and not draining; out-of-range beats are dropped.
module demux_seq #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input logic        clk,
  input logic        reset,
  demux_seq_if.slave bus
);

  logic [SEL_W-1:0]          tgt;
  logic [SEL_W-1:0]          ptr_q;
  logic [CHANNELS-1:0]       hit;
  logic [CHANNELS-1:0]       vld_q;
  logic [CHANNELS*WIDTH-1:0] dat_q;
  logic                      in_range;
  logic                      busy;
  logic                      accept;
  logic                      err_q;

  // Decode the target into a one-hot channel hit; an all-zero hit means out of range.
  always_comb begin
    tgt = bus.mode ? ptr_q : bus.sel;
    hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      hit[k] = (tgt == SEL_W'(k));
    end
  end

  assign in_range     = |hit;
  // A full target that drains this cycle can still take a new beat (full throughput).
  assign busy         = |(hit & vld_q & ~bus.out_ready);
  assign bus.in_ready = ~busy;
  assign accept       = bus.in_valid & ~busy;

  // Per-channel one-entry registers: reload wins over drain, data only changes on reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (accept && hit[k]) begin
          vld_q[k]                <= 1'b1;
          dat_q[k*WIDTH +: WIDTH] <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances only on auto-mode accepts; drop pulse for out-of-range beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !in_range;
      if (accept && bus.mode) begin
        ptr_q <= (ptr_q == SEL_W'(CHANNELS-1)) ? '0 : ptr_q + SEL_W'(1);
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = dat_q;
  assign bus.ptr       = ptr_q;
  assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_demux_seq.sv
// Bench for demux_seq: 8-channel instance checked against a channel-array model,
// plus a 6-channel instance for the out-of-range drop path.
module tb_demux_seq;

  logic clk;
  logic reset;

  demux_seq_if #(.WIDTH(4), .CHANNELS(8)) bus8 ();
  demux_seq_if #(.WIDTH(4), .CHANNELS(6)) bus6 ();

  demux_seq #(.WIDTH(4), .CHANNELS(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  demux_seq #(.WIDTH(4), .CHANNELS(6)) u_dut6 (.clk(clk), .reset(reset), .bus(bus6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the 8-channel instance: one slot per channel plus a pointer.
  bit       m_vld [8];
  bit [3:0] m_dat [8];
  int       m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = 4'h0;
    end
    m_ptr = 0;
  endtask

  function automatic logic [7:0] model_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_vld[k];
    return v;
  endfunction

  function automatic logic [31:0] model_data();
    logic [31:0] d;
    for (int k = 0; k < 8; k++) d[k*4 +: 4] = m_dat[k];
    return d;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, bus8.out_valid, model_valid());
    chk({tag, ".out_data"},  bus8.out_data,  model_data());
    chk({tag, ".ptr"},       bus8.ptr,       m_ptr);
    chk({tag, ".sel_err"},   bus8.sel_err,   1'b0);
  endtask

  // One clock of traffic on the 8-channel instance, checked before and after the edge.
  task automatic step(input bit iv, input bit [3:0] d, input bit [2:0] s, input bit md,
                      input bit [7:0] ordy, input string tag);
    int t;
    bit rdy;
    @(negedge clk);
    bus8.in_valid  = iv;
    bus8.in_data   = d;
    bus8.sel       = s;
    bus8.mode      = md;
    bus8.out_ready = ordy;
    #1;
    t   = md ? m_ptr : int'(s);
    rdy = !m_vld[t] || ordy[t];
    chk({tag, ".in_ready"}, bus8.in_ready, rdy);
    for (int k = 0; k < 8; k++) begin
      if (m_vld[k] && ordy[k]) m_vld[k] = 1'b0;
    end
    if (iv && rdy) begin
      m_vld[t] = 1'b1;
      m_dat[t] = d;
      if (md) m_ptr = (m_ptr + 1) % 8;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Raise reset between edges and confirm outputs clear without waiting for a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus6.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_outputs(tag);
    chk({tag, ".dut6_valid"}, bus6.out_valid, 6'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = 4'h0;
    bus8.sel       = 3'd0;
    bus8.mode      = 1'b0;
    bus8.out_ready = 8'h00;
    bus6.in_valid  = 1'b0;
    bus6.in_data   = 4'h0;
    bus6.sel       = 3'd0;
    bus6.mode      = 1'b0;
    bus6.out_ready = 6'h00;
    model_clear();

    // Reset state, including in_ready with every channel empty.
    #1;
    check_outputs("reset");
    chk("reset.in_ready", bus8.in_ready, 1'b1);
    chk("reset.dut6_err", bus6.sel_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Manual select into channel 3, then a blocked second beat.
    step(1'b1, 4'hA, 3'd3, 1'b0, 8'h00, "man1");
    chk("man1.valid_const", bus8.out_valid, 8'b0000_1000);
    chk("man1.slice3", bus8.out_data[15:12], 4'hA);
    step(1'b1, 4'h5, 3'd3, 1'b0, 8'h00, "man2");
    step(1'b0, 4'h0, 3'd3, 1'b0, 8'h08, "man_drain");

    // Full throughput on channel 5.
    step(1'b1, 4'h1, 3'd5, 1'b0, 8'h20, "thr1");
    step(1'b1, 4'h2, 3'd5, 1'b0, 8'h20, "thr2");
    chk("thr2.slice5", bus8.out_data[23:20], 4'h2);
    step(1'b1, 4'h3, 3'd5, 1'b0, 8'h20, "thr3");
    chk("thr3.slice5", bus8.out_data[23:20], 4'h3);
    step(1'b0, 4'h0, 3'd0, 1'b0, 8'h20, "thr_drain");

    // Round-robin wrap from a fresh pointer.
    async_reset("rst1");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'(i), 3'd0, 1'b1, 8'hFF, "rr");
    end
    chk("rr.ptr_end", bus8.ptr, 3'd2);
    chk("rr.slice0", bus8.out_data[3:0], 4'h8);
    chk("rr.slice1", bus8.out_data[7:4], 4'h9);
    chk("rr.slice7", bus8.out_data[31:28], 4'h7);

    // Auto-mode backpressure: pointer sits on full channel 2 until it drains.
    step(1'b0, 4'h0, 3'd0, 1'b0, 8'hFF, "bp_idle");
    step(1'b1, 4'hC, 3'd2, 1'b0, 8'h00, "bp_fill");
    step(1'b1, 4'hD, 3'd0, 1'b1, 8'h00, "bp_block1");
    step(1'b1, 4'hD, 3'd0, 1'b1, 8'h00, "bp_block2");
    chk("bp.ptr_hold", bus8.ptr, 3'd2);
    step(1'b1, 4'hD, 3'd0, 1'b1, 8'h04, "bp_release");
    chk("bp.ptr_adv", bus8.ptr, 3'd3);

    // Random traffic with mode flips and independent drains.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
           8'($urandom), "rand");
    end

    // Async reset with three held beats; first auto accept afterwards lands on channel 0.
    step(1'b0, 4'h0, 3'd0, 1'b0, 8'hFF, "pre_idle");
    step(1'b1, 4'h6, 3'd1, 1'b0, 8'h00, "hold1");
    step(1'b1, 4'h7, 3'd4, 1'b0, 8'h00, "hold4");
    step(1'b1, 4'h9, 3'd6, 1'b0, 8'h00, "hold6");
    async_reset("rst2");
    step(1'b1, 4'hE, 3'd5, 1'b1, 8'h00, "post_rst");
    chk("post_rst.valid_const", bus8.out_valid, 8'b0000_0001);

    // Six-channel instance: select 7 is consumed, dropped and flagged once.
    @(negedge clk);
    bus6.in_valid = 1'b1;
    bus6.in_data  = 4'h9;
    bus6.sel      = 3'd7;
    bus6.mode     = 1'b0;
    #1;
    chk("oor.in_ready", bus6.in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("oor.valid", bus6.out_valid, 6'h00);
    chk("oor.err_pulse", bus6.sel_err, 1'b1);
    chk("oor.data", bus6.out_data, 24'h0);
    @(negedge clk);
    bus6.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("oor.err_clear", bus6.sel_err, 1'b0);
    @(negedge clk);
    bus6.in_valid = 1'b1;
    bus6.in_data  = 4'hB;
    bus6.sel      = 3'd5;
    @(posedge clk);
    #1;
    chk("c6.valid5", bus6.out_valid, 6'b10_0000);
    chk("c6.slice5", bus6.out_data[23:20], 4'hB);
    chk("c6.no_err", bus6.sel_err, 1'b0);
    @(negedge clk);
    bus6.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_seq.md
DEMUX_SEQ -- requirements
Module: demux_seq

Interface
REQ-001 Parameter WIDTH, default 1, data bits per beat (>=1).
REQ-002 Parameter CHANNELS, default 8, number of output channels (2..64).
REQ-003 Parameter SEL_W, default $clog2(CHANNELS), select/pointer width.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port in_valid  input  1  upstream beat present.
REQ-007 Port in_ready  output  1  block accepts beat this cycle.
REQ-008 Port in_data  input  WIDTH  upstream beat payload.
REQ-009 Port sel  input  SEL_W  target channel in manual mode.
REQ-010 Port mode  input  1  0 = manual select, 1 = auto round-robin.
REQ-011 Port out_valid  output  CHANNELS  per-channel beat held.
REQ-012 Port out_ready  input  CHANNELS  per-channel downstream accept.
REQ-013 Port out_data  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 Port ptr  output  SEL_W  current round-robin pointer.
REQ-015 Port sel_err  output  1  one-cycle pulse: beat dropped for out-of-range select.

Function
REQ-016 Target channel t SHALL be sel when mode=0, ptr when mode=1; mode sampled each cycle, no latching.
REQ-017 Each channel SHALL own a one-entry register (out_data slice + out_valid bit).
REQ-018 in_ready SHALL be combinational: 1 when t >= CHANNELS, else (~out_valid[t] | out_ready[t]).
REQ-019 Accept = in_valid & in_ready; on accept with t < CHANNELS, out_data[t] <= in_data and out_valid[t] <= 1 at that clock edge (latency 1 cycle).
REQ-020 Channel k drain = out_valid[k] & out_ready[k]; drain without reload of k clears out_valid[k]; drain and reload same cycle keeps out_valid[k]=1 with new data (full throughput, 1 beat/cycle).
REQ-021 out_data of non-target channels and drained channels SHALL hold last value; no zeroing.
REQ-022 Multiple channels SHALL drain independently in the same cycle.
REQ-023 ptr SHALL increment by 1 on every accept while mode=1, wrapping CHANNELS-1 -> 0; ptr SHALL hold in mode=0 and on no-accept cycles.
REQ-024 Accept with t >= CHANNELS (only possible when CHANNELS not a power of two, manual mode) SHALL consume and discard the beat, no channel updated, sel_err=1 next cycle for one cycle.
REQ-025 out_valid/out_data SHALL never change in a channel except by reload (REQ-019) or drain (REQ-020).
REQ-026 Mode change mid-stream SHALL take effect the same cycle; ptr retains its value across mode changes.
REQ-027 out_ready on a channel with out_valid=0 SHALL have no effect.

Reset
REQ-028 While reset=1, immediately and independent of clk: out_valid=0, out_data=0, ptr=0, sel_err=0.
REQ-029 Reset mid-operation SHALL discard all held beats; first accept after release targets sel (mode=0) or channel 0 (mode=1).
REQ-030 in_ready after reset SHALL follow REQ-018 with all channels empty (1 for any in-range t).

Verification (CHANNELS=8, WIDTH=4 unless stated)
REQ-031 Manual: mode=0, sel=3, in_data=4'hA, in_valid 1 cycle, out_ready=0 -> out_valid=8'b0000_1000, out_data[15:12]=A next cycle; other slices unchanged; second beat to sel=3 sees in_ready=0.
REQ-032 Full throughput: sel=5, out_ready[5]=1, beats 1,2,3 back-to-back -> in_ready stays 1, out_data[23:20] shows 1,2,3 on successive cycles, out_valid[5] stays 1.
REQ-033 Round-robin wrap: mode=1, all out_ready=1, 10 beats 0..9 -> channels 0..7 receive 0..7, channels 0,1 then receive 8,9; ptr=2 at end.
REQ-034 Backpressure in auto: mode=1, out_ready=0, ptr at channel 2 already full -> in_ready=0, ptr holds 2 until out_ready[2] pulse.
REQ-035 Out-of-range: CHANNELS=6, sel=7, in_valid 1 cycle -> in_ready=1, no out_valid change, sel_err pulses once.
REQ-036 Async reset: three channels holding beats, assert reset between clock edges -> out_valid=0, out_data=0, ptr=0 before next edge.
